// File: rtl/scr1_dp_memory_init_if.sv
// -----------------------------------------------------------------------------
// scr1_dp_memory_init_if
// Bus bundle for the dual-port memory with power-on zero fill.
//   ready         : memory initialised, both ports accept requests
//   rena/addra    : port A read request, ABYTES-granular address
//   qa/qa_vld     : port A read data and "updated last cycle" flag
//   renb/wenb     : port B read / write requests
//   webb/addrb    : port B byte enables and word address
//   datab         : port B write data
//   qb/qb_vld     : port B read data and "updated last cycle" flag
// master = requester side, slave = memory side.
// -----------------------------------------------------------------------------
interface scr1_dp_memory_init_if #(
   parameter int unsigned SCR1_SIZE   = 32'h00010000,
   parameter int unsigned SCR1_DWIDTH = 64,
   parameter int unsigned SCR1_AWIDTH = 32
);
   localparam int unsigned AMSB = $clog2(SCR1_SIZE) - 1;
   localparam int unsigned ALSB = $clog2(SCR1_AWIDTH / 8);
   localparam int unsigned BLSB = $clog2(SCR1_DWIDTH / 8);

   logic                     ready;
   logic                     rena;
   logic [AMSB:ALSB]         addra;
   logic [SCR1_AWIDTH-1:0]   qa;
   logic                     qa_vld;
   logic                     renb;
   logic                     wenb;
   logic [SCR1_DWIDTH/8-1:0] webb;
   logic [AMSB:BLSB]         addrb;
   logic [SCR1_DWIDTH-1:0]   datab;
   logic [SCR1_DWIDTH-1:0]   qb;
   logic                     qb_vld;

   modport master (
      input  ready, qa, qa_vld, qb, qb_vld,
      output rena, addra, renb, wenb, webb, addrb, datab
   );

   modport slave (
      output ready, qa, qa_vld, qb, qb_vld,
      input  rena, addra, renb, wenb, webb, addrb, datab
   );
endinterface

// File: rtl/scr1_dp_memory_init.sv
// -----------------------------------------------------------------------------
// scr1_dp_memory_init
// Dual-port RAM: port A is a narrow (SCR1_AWIDTH) read-only port, port B a
// full-word read/write port with byte enables. After reset the array is
// optionally zero-filled one word per cycle; ready stays low until the fill
// completes and all port requests are ignored meanwhile.
// Ports:
//   i_clk   : clock, everything on the rising edge
//   i_rst_n : synchronous active-low reset
//   io_bus  : scr1_dp_memory_init_if.slave (see interface header)
// Read latency is one cycle on both ports. Port B is read-first for its own
// write; port A sees a same-cycle port B write to its word (write-first).
// -----------------------------------------------------------------------------
module scr1_dp_memory_init #(
   parameter int unsigned SCR1_SIZE    = 32'h00010000,
   parameter int unsigned SCR1_DWIDTH  = 64,
   parameter int unsigned SCR1_AWIDTH  = 32,
   parameter bit          SCR1_INIT_EN = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   scr1_dp_memory_init_if.slave  io_bus
);

   localparam int unsigned DBYTES = SCR1_DWIDTH / 8;
   localparam int unsigned ABYTES = SCR1_AWIDTH / 8;
   localparam int unsigned WORDS  = SCR1_SIZE / DBYTES;
   localparam int unsigned NCHUNK = DBYTES / ABYTES;
   localparam int unsigned SEL    = $clog2(NCHUNK);
   localparam int unsigned WAW    = $clog2(WORDS);
   localparam int unsigned AMSB   = $clog2(SCR1_SIZE) - 1;
   localparam int unsigned ALSB   = $clog2(ABYTES);
   localparam int unsigned BLSB   = $clog2(DBYTES);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [WAW-1:0]         r_cnt;
   logic [WAW-1:0]         w_cnt_next;
   logic                   w_fill_we;
   logic                   r_ready;

   logic [SCR1_DWIDTH-1:0] r_mem [WORDS];

   logic                   w_rd_a;
   logic                   w_rd_b;
   logic                   w_wr_b;
   logic [WAW-1:0]         w_worda;
   logic [SCR1_DWIDTH-1:0] w_worda_fwd;
   logic [SCR1_AWIDTH-1:0] w_qa;

   logic [SCR1_AWIDTH-1:0] r_qa;
   logic                   r_qa_vld;
   logic [SCR1_DWIDTH-1:0] r_qb;
   logic                   r_qb_vld;

   // ---- control: fill FSM state register ----
   // ready is registered off the next state so it is low during reset even
   // when the fill is disabled and the FSM resets straight into RUN.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= SCR1_INIT_EN ? ST_INIT : ST_RUN;
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_ready <= (w_state_next == ST_RUN);
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_fill_we    = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_fill_we  = 1'b1;
            w_cnt_next = r_cnt + 1'b1;
            if (r_cnt == WAW'(WORDS - 1)) begin
               w_state_next = ST_RUN;
               w_cnt_next   = '0;
            end
         end
         ST_RUN: begin
            w_state_next = ST_RUN;
         end
         default: begin
            w_state_next = ST_INIT;
            w_cnt_next   = '0;
         end
      endcase
   end

   // Requests count only once the fill is over.
   assign w_rd_a  = r_ready & io_bus.rena;
   assign w_rd_b  = r_ready & io_bus.renb;
   assign w_wr_b  = r_ready & io_bus.wenb;
   assign w_worda = io_bus.addra[AMSB:BLSB];

   // ---- storage: fill or byte-masked port B write ----
   always_ff @(posedge i_clk) begin
      if (i_rst_n && w_fill_we) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_b) begin
         for (int i = 0; i < DBYTES; i++) begin
            if (io_bus.webb[i]) begin
               r_mem[io_bus.addrb][i*8 +: 8] <= io_bus.datab[i*8 +: 8];
            end
         end
      end
   end

   // Port A forwarding: merge enabled bytes of a same-cycle port B write.
   always_comb begin
      w_worda_fwd = r_mem[w_worda];
      if (w_wr_b && (io_bus.addrb == w_worda)) begin
         for (int i = 0; i < DBYTES; i++) begin
            if (io_bus.webb[i]) begin
               w_worda_fwd[i*8 +: 8] = io_bus.datab[i*8 +: 8];
            end
         end
      end
   end

   generate
      if (SEL == 0) begin : g_nosel
         assign w_qa = w_worda_fwd;
      end else begin : g_sel
         logic [NCHUNK-1:0][SCR1_AWIDTH-1:0] w_chunks;
         assign w_chunks = w_worda_fwd;
         assign w_qa     = w_chunks[io_bus.addra[BLSB-1:ALSB]];
      end
   endgenerate

   // ---- read output registers (one-cycle latency) ----
   // Port B read uses the pre-write array value, giving read-first behaviour.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_qa     <= '0;
         r_qa_vld <= 1'b0;
         r_qb     <= '0;
         r_qb_vld <= 1'b0;
      end else begin
         r_qa_vld <= w_rd_a;
         r_qb_vld <= w_rd_b;
         if (w_rd_a) begin
            r_qa <= w_qa;
         end
         if (w_rd_b) begin
            r_qb <= r_mem[io_bus.addrb];
         end
      end
   end

   assign io_bus.ready  = r_ready;
   assign io_bus.qa     = r_qa;
   assign io_bus.qa_vld = r_qa_vld;
   assign io_bus.qb     = r_qb;
   assign io_bus.qb_vld = r_qb_vld;

endmodule
